// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory request sequencer.
//   ADDR_W_DEF : default number of word-address bits decoded by the data memory
//   op_e       : request opcodes
//   state_e    : sequencer FSM state encoding
package mem_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    OP_RD_SINGLE = 2'b00,
    OP_RD_PAIR   = 2'b01,
    OP_WRITE     = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_addr_check.sv
// mem_addr_check: combinational range test for a 32-bit word address.
//   i_addr : address under test
//   o_oor  : high when any bit above the decoded range [31:ADDR_W] is set
module mem_addr_check #(
  parameter int ADDR_W = mem_pkg::ADDR_W_DEF
) (
  input  logic [31:0] i_addr,
  output logic        o_oor
);

  assign o_oor = |i_addr[31:ADDR_W];

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: accepts one read-single / read-pair / write request at a
// time, sequences it onto a synchronous data memory and holds the response
// until consumed.
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/req_ready, req_*       : request handshake and payload
//   rsp_valid/rsp_ready, rsp_*       : response handshake and payload
//   addrA/addrB/addrWR/write_data    : memory address/data
//   memread/memwrite                 : memory strobes
//   read_dataA/read_dataB            : registered memory read data
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | req_ready high, waiting for a request
// ST_ISSUE   | memread high, memory registers read data at the next edge
// ST_CAPTURE | memory data valid, captured into the response registers
// ST_WRITE   | memwrite high for one cycle (or one empty cycle on error)
// ST_RESP    | rsp_valid held until rsp_ready
module mem_req_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr_a,
  input  logic [31:0] req_addr_b,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data_a,
  output logic [31:0] rsp_data_b,
  output logic        rsp_err,
  output logic [31:0] addrA,
  output logic [31:0] addrB,
  output logic [31:0] addrWR,
  output logic [31:0] write_data,
  output logic        memread,
  output logic        memwrite,
  input  logic [31:0] read_dataA,
  input  logic [31:0] read_dataB
);

  state_e      r_state;
  state_e      w_next;
  op_e         r_op;
  logic [31:0] r_addr_a;
  logic [31:0] r_addr_b;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rsp_a;
  logic [31:0] r_rsp_b;

  logic w_oor_a;
  logic w_oor_b;
  logic w_req_err;
  logic w_accept;

  mem_addr_check #(.ADDR_W(ADDR_W)) u_chk_a (.i_addr(req_addr_a), .o_oor(w_oor_a));
  mem_addr_check #(.ADDR_W(ADDR_W)) u_chk_b (.i_addr(req_addr_b), .o_oor(w_oor_b));

  // addr_b only matters for read-pair
  assign w_req_err = (op_e'(req_op) == OP_RSVD) || w_oor_a ||
                     ((op_e'(req_op) == OP_RD_PAIR) && w_oor_b);
  assign w_accept  = (r_state == ST_IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_RD_SINGLE;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rsp_a  <= '0;
      r_rsp_b  <= '0;
    end else if (w_accept) begin
      r_op     <= op_e'(req_op);
      r_addr_a <= req_addr_a;
      r_addr_b <= req_addr_b;
      r_wdata  <= req_wdata;
      r_err    <= w_req_err;
      r_rsp_a  <= '0;
      r_rsp_b  <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_a <= read_dataA;
      r_rsp_b <= (r_op == OP_RD_PAIR) ? read_dataB : '0;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    addrA      = r_addr_a;
    addrB      = (r_op == OP_RD_PAIR) ? r_addr_b : r_addr_a;
    addrWR     = r_addr_a;
    write_data = r_wdata;
    rsp_data_a = r_rsp_a;
    rsp_data_b = r_rsp_b;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // rejected requests pass through ST_WRITE with the strobe masked so
          // they answer one cycle after accept, like a write
          if (w_req_err || (op_e'(req_op) == OP_WRITE)) w_next = ST_WRITE;
          else                                          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        memread = 1'b1;
        w_next  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_RESP;
      end
      ST_WRITE: begin
        memwrite = !r_err;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
module tb_mem_req_sequencer;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr_a = '0;
  logic [31:0] req_addr_b = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic        rsp_err;
  logic [31:0] addrA, addrB, addrWR, write_data;
  logic        memread, memwrite;
  logic [31:0] read_dataA = '0;
  logic [31:0] read_dataB = '0;

  mem_req_sequencer #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_err(rsp_err),
    .addrA(addrA), .addrB(addrB), .addrWR(addrWR), .write_data(write_data),
    .memread(memread), .memwrite(memwrite),
    .read_dataA(read_dataA), .read_dataB(read_dataB)
  );

  always #5 clk = ~clk;

  // data memory model: word i preloaded with i
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = i;

  always @(posedge clk) begin
    if (memread) begin
      read_dataA <= mem[addrA[4:0]];
      read_dataB <= mem[addrB[4:0]];
    end
  end

  always @(negedge clk) begin
    if (memwrite) mem[addrWR[4:0]] <= write_data;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // monitor: strobe accounting and scoreboard check on every response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (memread)  rd_cnt++;
      if (memwrite) wr_cnt++;
      if (memread && memwrite) chk1("strobe_exclusive", 1'b1, 1'b0);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk1("unexpected_response", 1'b1, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_data_a", rsp_data_a, mon_e.a);
          chk("rsp_data_b", rsp_data_b, mon_e.b);
          chk1("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] ea, input logic [31:0] eb, input logic ee,
                        input int exp_rd, input int exp_wr, input int stall);
    int lat;
    @(negedge clk);
    chk1("req_ready_idle", req_ready, 1'b1);
    sb_q.push_back(rsp_t'{a: ea, b: eb, err: ee});
    rd_cnt = 0;
    wr_cnt = 0;
    req_valid = 1'b1; req_op = op; req_addr_a = a; req_addr_b = b; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", lat, exp_lat);
    if (!rsp_valid) begin
      $display("FAIL rsp_timeout: no rsp_valid within 20 cycles");
      void'(sb_q.pop_back());
      return;
    end
    for (int i = 0; i < stall; i++) begin
      chk1("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_data_a", rsp_data_a, ea);
      chk("stall_data_b", rsp_data_b, eb);
      chk1("stall_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk1("idle_req_ready", req_ready, 1'b1);
    chk1("idle_rsp_valid", rsp_valid, 1'b0);
    chk("memread_cycles", rd_cnt, exp_rd);
    chk("memwrite_cycles", wr_cnt, exp_wr);
  endtask

  initial begin
    #22;
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_memread", memread, 1'b0);
    chk1("rst_memwrite", memwrite, 1'b0);
    chk("rst_addrA", addrA, 32'h0);
    chk("rst_addrWR", addrWR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rst_req_ready", req_ready, 1'b1);

    //     op     addr_a        addr_b        wdata         lat  exp_a         exp_b  err   rd wr stall
    do_req(2'b00, 32'd7,        32'd0,        32'h0,        2,   32'd7,        32'd0, 1'b0, 1, 0, 0);
    do_req(2'b01, 32'd3,        32'd31,       32'h0,        2,   32'd3,        32'd31,1'b0, 1, 0, 0);
    do_req(2'b10, 32'd5,        32'd0,        32'hDEADBEEF, 1,   32'd0,        32'd0, 1'b0, 0, 1, 0);
    chk("mem5_written", mem[5], 32'hDEADBEEF);
    do_req(2'b00, 32'd5,        32'd0,        32'h0,        2,   32'hDEADBEEF, 32'd0, 1'b0, 1, 0, 0);
    do_req(2'b01, 32'd2,        32'd32,       32'h0,        1,   32'd0,        32'd0, 1'b1, 0, 0, 0);
    do_req(2'b10, 32'h100,      32'd0,        32'h55,       1,   32'd0,        32'd0, 1'b1, 0, 0, 0);
    chk("mem0_unchanged", mem[0], 32'd0);
    do_req(2'b11, 32'd1,        32'd1,        32'h0,        1,   32'd0,        32'd0, 1'b1, 0, 0, 0);
    do_req(2'b00, 32'd31,       32'hFFFFFFFF, 32'h0,        2,   32'd31,       32'd0, 1'b0, 1, 0, 0);
    do_req(2'b00, 32'h80000000, 32'd0,        32'h0,        1,   32'd0,        32'd0, 1'b1, 0, 0, 0);
    do_req(2'b01, 32'd31,       32'd0,        32'h0,        2,   32'd31,       32'd0, 1'b0, 1, 0, 10);

    // reset pulse while a write is in ST_WRITE, before the committing falling edge
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr_a = 32'd9; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk1("wr_before_reset", memwrite, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("abort_memwrite", memwrite, 1'b0);
    chk1("abort_memread", memread, 1'b0);
    chk1("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_addrWR", addrWR, 32'h0);
    chk("abort_write_data", write_data, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mem9_kept", mem[9], 32'd9);
    chk1("abort_req_ready", req_ready, 1'b1);
    do_req(2'b00, 32'd9,        32'd0,        32'h0,        2,   32'd9,        32'd0, 1'b0, 1, 0, 0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 5, word-address bits the data memory decodes (32 words).
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  request offered.
REQ-005 SHALL have port: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port: req_op  in  2  00 read-single, 01 read-pair, 10 write, 11 reserved.
REQ-007 SHALL have port: req_addr_a  in  32  read address A / write address.
REQ-008 SHALL have port: req_addr_b  in  32  read address B (read-pair only).
REQ-009 SHALL have port: req_wdata  in  32  write data.
REQ-010 SHALL have port: rsp_valid  out  1  response held.
REQ-011 SHALL have port: rsp_ready  in  1  response consumed.
REQ-012 SHALL have port: rsp_data_a, rsp_data_b  out  32 each  read results.
REQ-013 SHALL have port: rsp_err  out  1  request rejected.
REQ-014 SHALL have port: addrA, addrB, addrWR, write_data  out  32 each  to data memory.
REQ-015 SHALL have port: memread, memwrite  out  1 each  memory strobes.
REQ-016 SHALL have port: read_dataA, read_dataB  in  32 each  from data memory (registered on rising edge when memread sampled high).

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, CAPTURE, WRITE, RESP; all outputs registered or decoded from state only.
REQ-018 SHALL assert req_ready only in IDLE; one outstanding transaction.
REQ-019 SHALL, on accept (edge k), latch op, addresses, wdata; a read with in-range addresses goes to ISSUE.
REQ-020 SHALL drive memread=1 only in ISSUE; addrA=latched addr_a, addrB=latched addr_b (read-pair) or addr_a (read-single).
REQ-021 SHALL in CAPTURE sample read_dataA/B at edge k+2 into rsp_data_a/b and enter RESP; rsp_data_b=0 for read-single; read latency accept-to-rsp_valid = 2 cycles.
REQ-022 SHALL for in-range write go to WRITE, drive memwrite=1, addrWR=addr_a, write_data=wdata for exactly one full cycle (memory commits at falling edge mid-cycle); enter RESP at k+1 with data 0, err 0.
REQ-023 SHALL treat address out of range when any bit [31:ADDR_W] is set (either address for read-pair); no memory strobe; RESP at k+1 with rsp_err=1, data 0.
REQ-024 SHALL treat op 11 as error, same as REQ-023.
REQ-025 SHALL hold rsp_valid and all rsp fields stable in RESP until rsp_ready=1; then return to IDLE next edge (no same-cycle re-accept).
REQ-026 SHALL keep memread and memwrite never simultaneously high, and both low outside ISSUE/WRITE.
REQ-027 SHALL guarantee read-after-write: a read accepted after a write's RESP returns the written value.

Reset
REQ-028 SHALL on rst_n=0 immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, memread=0, memwrite=0, all data/address outputs 0.
REQ-029 SHALL on reset during WRITE before the falling edge drop memwrite asynchronously (write aborted); in-flight read/response discarded.

Structure
REQ-030 SHALL place op codes, FSM state encoding and ADDR_W default in shared package mem_pkg.
REQ-031 SHALL use one sub-module mem_addr_check (combinational range test, ADDR_W parameter), instantiated for addr_a and addr_b.

Verification
REQ-032 Memory model preloaded word i = i; read-single addr 7 -> rsp_valid 2 cycles after accept, rsp_data_a=7, rsp_data_b=0, err 0.
REQ-033 Read-pair addrs 3, 31 -> rsp_data_a=3, rsp_data_b=31; memread high exactly one cycle.
REQ-034 Write 0xDEADBEEF to 5, then read-single 5 -> 0xDEADBEEF; memwrite high exactly one cycle.
REQ-035 Read-pair addrs 2, 32 -> rsp_err=1 at k+1, no memread pulse; write to 0x100 -> err, memory unchanged.
REQ-036 rsp_ready held low 10 cycles -> rsp_valid and data stable, req_ready low throughout; release -> IDLE next edge.
REQ-037 rst_n pulsed low during WRITE before falling edge -> memwrite drops at once, target word keeps old value, outputs at reset values.
